// File: rtl/calc_console.sv
// Switch calculator console: debounced mode buttons, registered ALU result,
// LED/seven-segment output decode and a bouncing LED chase in mode 3.
//
// state       | meaning
// MODE_ARITH  | add / subtract (magnitude + sign) / multiply / max
// MODE_LOGIC  | and / or / xor / nand of zero-extended operands
// MODE_CMP    | equal / greater / less / min
// MODE_CHASE  | one-hot LED bouncing between the ends of the bank
module calc_console #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 1000000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [1:0]                buttons,
  input  logic [2*WIDTH+1:0]        switches,
  output logic [2*WIDTH+1:0]        LEDs,
  output logic [7*(WIDTH/2)-1:0]    result_seg,
  output logic [6:0]                sign_seg,
  output logic [6:0]                mode_seg
);

  localparam int R      = 2 * WIDTH;
  localparam int DIGITS = WIDTH / 2;
  localparam int L      = 2 * WIDTH + 2;
  localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TKW    = $clog2(TICK_CYCLES + 1);
  localparam int PW     = $clog2(L);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0]  POS_TOP   = PW'(L - 1);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    MODE_ARITH = 2'd0,
    MODE_LOGIC = 2'd1,
    MODE_CMP   = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [1:0]     sync1, sync2, clean, press;
  logic [DBW-1:0] db_cnt [2];

  // Clean level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      clean <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= ~buttons;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == clean[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          clean[i]  <= ~clean[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  mode_t mode, mode_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mode <= MODE_ARITH;
    else          mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    if (press[0] && !press[1])      mode_next = mode_t'(mode + 2'd1);
    else if (press[1] && !press[0]) mode_next = mode_t'(mode - 2'd1);
  end

  logic [1:0]       op;
  logic [WIDTH-1:0] op_a, op_b, diff_ab, diff_ba, nand_ab;
  logic [WIDTH:0]   sum;
  logic [R-1:0]     a_ext, b_ext, res_next, result;
  logic             flag_next, neg_next, flag, neg;

  assign op      = switches[2*WIDTH+1:2*WIDTH];
  assign op_a    = switches[2*WIDTH-1:WIDTH];
  assign op_b    = switches[WIDTH-1:0];
  assign sum     = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ab = op_a - op_b;
  assign diff_ba = op_b - op_a;
  assign nand_ab = ~(op_a & op_b);
  assign a_ext   = R'(op_a);
  assign b_ext   = R'(op_b);

  always_comb begin
    res_next  = '0;
    flag_next = 1'b0;
    neg_next  = 1'b0;
    case (mode)
      MODE_ARITH: begin
        case (op)
          2'd0: begin
            res_next  = R'(sum);
            flag_next = sum[WIDTH];
          end
          2'd1: begin
            if (op_a < op_b) begin
              res_next  = R'(diff_ba);
              flag_next = 1'b1;
              neg_next  = 1'b1;
            end else begin
              res_next  = R'(diff_ab);
            end
          end
          2'd2:    res_next = a_ext * b_ext;
          default: res_next = (op_a > op_b) ? a_ext : b_ext;
        endcase
      end
      MODE_LOGIC: begin
        case (op)
          2'd0:    res_next = a_ext & b_ext;
          2'd1:    res_next = a_ext | b_ext;
          2'd2:    res_next = a_ext ^ b_ext;
          default: res_next = R'(nand_ab);
        endcase
      end
      MODE_CMP: begin
        case (op)
          2'd0:    res_next = R'(op_a == op_b);
          2'd1:    res_next = R'(op_a > op_b);
          2'd2:    res_next = R'(op_a < op_b);
          default: res_next = (op_a < op_b) ? a_ext : b_ext;
        endcase
      end
      default: res_next = '0;
    endcase
  end

  // neg remembers that the flag came from a negative subtraction, not a carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      flag   <= 1'b0;
      neg    <= 1'b0;
    end else begin
      result <= res_next;
      flag   <= flag_next;
      neg    <= neg_next;
    end
  end

  logic [TKW-1:0] tick_cnt;
  logic [PW-1:0]  pos;
  logic           dir_up;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      pos      <= '0;
      dir_up   <= 1'b1;
    end else if (mode_next != mode) begin
      tick_cnt <= '0;
      pos      <= '0;
      dir_up   <= 1'b1;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      if (dir_up) begin
        if (pos == POS_TOP) begin
          dir_up <= 1'b0;
          pos    <= pos - PW'(1);
        end else begin
          pos    <= pos + PW'(1);
        end
      end else begin
        if (pos == '0) begin
          dir_up <= 1'b1;
          pos    <= PW'(1);
        end else begin
          pos    <= pos - PW'(1);
        end
      end
    end else begin
      tick_cnt <= tick_cnt + TKW'(1);
    end
  end

  always_comb begin
    LEDs       = '0;
    result_seg = '1;
    sign_seg   = SEG_BLANK;
    mode_seg   = hex7({2'b00, mode});
    if (mode == MODE_CHASE) begin
      LEDs[pos] = 1'b1;
    end else begin
      LEDs = {flag, 1'b0, result};
      for (int d = 0; d < DIGITS; d++) result_seg[7*d +: 7] = hex7(result[4*d +: 4]);
      sign_seg = neg ? SEG_MINUS : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_calc_console.sv
// Directed bench for calc_console: ALU vector table plus button, chase and
// asynchronous reset sequences with WIDTH=4, DEBOUNCE_CYCLES=4, TICK_CYCLES=3.
module tb_calc_console;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] buttons = 2'b11;
  logic [9:0] switches = 10'h3FF;
  logic [9:0] LEDs;
  logic [13:0] result_seg;
  logic [6:0] sign_seg, mode_seg;

  calc_console #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .TICK_CYCLES(3)) dut (
    .clock(clock), .reset_n(reset_n), .buttons(buttons), .switches(switches),
    .LEDs(LEDs), .result_seg(result_seg), .sign_seg(sign_seg), .mode_seg(mode_seg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cur_mode = 0;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [1:0] mode;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       flag;
    logic       neg;
  } vec_t;

  vec_t vecs [18];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mask bit set = button held pressed (raw line low)
  task automatic press_hold(input logic [1:0] mask, input int hold, input int exp_mode);
    buttons = ~mask;
    repeat (hold) tick();
    if (hold >= 7) check("mode_held", mode_seg, seg_lut[exp_mode]);
    buttons = 2'b11;
    repeat (12) tick();
    cur_mode = exp_mode;
    check("mode_after_release", mode_seg, seg_lut[exp_mode]);
  endtask

  task automatic goto_mode(input int target);
    while (cur_mode != target) press_hold(2'b01, 8, (cur_mode + 1) % 4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'd0, 2'd0, 4'h9, 4'h8, 8'h11, 1'b1, 1'b0};
    vecs[1]  = '{2'd0, 2'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0};
    vecs[2]  = '{2'd0, 2'd1, 4'h3, 4'h7, 8'h04, 1'b1, 1'b1};
    vecs[3]  = '{2'd0, 2'd1, 4'h7, 4'h3, 8'h04, 1'b0, 1'b0};
    vecs[4]  = '{2'd0, 2'd3, 4'h2, 4'hC, 8'h0C, 1'b0, 1'b0};
    vecs[5]  = '{2'd0, 2'd0, 4'h3, 4'h4, 8'h07, 1'b0, 1'b0};
    vecs[6]  = '{2'd0, 2'd0, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0};
    vecs[7]  = '{2'd1, 2'd0, 4'hC, 4'hA, 8'h08, 1'b0, 1'b0};
    vecs[8]  = '{2'd1, 2'd1, 4'hC, 4'hA, 8'h0E, 1'b0, 1'b0};
    vecs[9]  = '{2'd1, 2'd2, 4'hC, 4'hA, 8'h06, 1'b0, 1'b0};
    vecs[10] = '{2'd1, 2'd3, 4'hF, 4'hF, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{2'd1, 2'd3, 4'h5, 4'h3, 8'h0E, 1'b0, 1'b0};
    vecs[12] = '{2'd2, 2'd0, 4'h5, 4'h5, 8'h01, 1'b0, 1'b0};
    vecs[13] = '{2'd2, 2'd1, 4'h5, 4'h5, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{2'd2, 2'd3, 4'h5, 4'h5, 8'h05, 1'b0, 1'b0};
    vecs[15] = '{2'd2, 2'd2, 4'h3, 4'h9, 8'h01, 1'b0, 1'b0};
    vecs[16] = '{2'd2, 2'd1, 4'h9, 4'h3, 8'h01, 1'b0, 1'b0};
    vecs[17] = '{2'd2, 2'd3, 4'h9, 4'h3, 8'h03, 1'b0, 1'b0};

    // asynchronous reset before any clock edge
    #1 reset_n = 1'b0;
    #2;
    check("rst_leds", LEDs, 10'h000);
    check("rst_result_seg", result_seg, {7'h40, 7'h40});
    check("rst_sign_seg", sign_seg, 7'h7F);
    check("rst_mode_seg", mode_seg, 7'h40);
    repeat (3) tick();
    @(negedge clock) reset_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      logic [7:0] r;
      if (int'(vecs[i].mode) != cur_mode) goto_mode(int'(vecs[i].mode));
      switches = {vecs[i].op, vecs[i].a, vecs[i].b};
      tick();
      r = vecs[i].res;
      check($sformatf("vec%0d_leds", i), LEDs, {vecs[i].flag, 1'b0, r});
      check($sformatf("vec%0d_result_seg", i), result_seg, {seg_lut[r[7:4]], seg_lut[r[3:0]]});
      check($sformatf("vec%0d_sign_seg", i), sign_seg, vecs[i].neg ? 7'h3F : 7'h7F);
      check($sformatf("vec%0d_mode_seg", i), mode_seg, seg_lut[cur_mode]);
    end

    goto_mode(0);
    press_hold(2'b10, 10, 3);
    press_hold(2'b01, 3, 3);
    press_hold(2'b11, 10, 3);
    press_hold(2'b01, 10, 0);

    // chase: mode changes on the 7th edge after the raw press
    buttons = 2'b01;
    repeat (7) tick();
    for (int k = 0; k < 20; k++) begin
      int p;
      p = (k <= 9) ? k : ((k <= 18) ? 18 - k : k - 18);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("chase%0d_%0d_leds", k, j), LEDs, 10'(1) << p);
        check("chase_result_seg", result_seg, 14'h3FFF);
        check("chase_sign_seg", sign_seg, 7'h7F);
        tick();
      end
    end
    buttons = 2'b11;
    repeat (12) tick();
    cur_mode = 3;
    check("chase_mode_seg", mode_seg, seg_lut[3]);

    press_hold(2'b01, 8, 0);
    check("mode0_max_leds", LEDs, 10'h009);
    check("mode0_max_seg", result_seg, {seg_lut[0], seg_lut[9]});

    buttons = 2'b01;
    repeat (7) tick();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("reenter%0d_%0d_leds", k, j), LEDs, 10'(1) << k);
        tick();
      end
    end
    check("reenter_pos2_leds", LEDs, 10'h004);

    // reset mid-operation, sampled before the next clock edge
    #2 reset_n = 1'b0;
    #1;
    check("midrst_leds", LEDs, 10'h000);
    check("midrst_result_seg", result_seg, {7'h40, 7'h40});
    check("midrst_sign_seg", sign_seg, 7'h7F);
    check("midrst_mode_seg", mode_seg, 7'h40);
    buttons = 2'b11;
    @(negedge clock) reset_n = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_console.md
# calc_console

Parametrised successor to the board-level switch calculator. It reads two WIDTH-bit operands and a 2-bit operation from the switches. Two debounced push-buttons cycle through four modes: arithmetic, logical, compare and LED chase. The block registers the result and drives LEDs plus active-low seven-segment digits (result, sign, mode). It sits directly under the board top and owns all button, LED and display behaviour.

## Interface
- WIDTH, 4: operand width in bits; must be even and ≥2; result width R = 2*WIDTH, result digits D = WIDTH/2.
- DEBOUNCE_CYCLES, 500000: number of consecutive stable synchronised cycles before a button level is accepted.
- TICK_CYCLES, 1000000: clock cycles per chase step.
- clock  in  1  system clock; every register is clocked on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- buttons  in  2  raw buttons, active-low when pressed; [0] = mode up, [1] = mode down.
- switches  in  2*WIDTH+2  operation and operands: op = [2W+1:2W], a = [2W-1:W], b = [W-1:0].
- LEDs  out  2*WIDTH+2  LED bank.
- result_seg  out  7*D  result digits, hex; [6:0] is the least-significant digit.
- sign_seg  out  7  sign digit.
- mode_seg  out  7  current mode digit (0–3).

## Operation
- Segment encoding: active-low, bit order gfedcba. '0' = 1000000, '-' = 0111111, blank = 1111111. Digits 0–F use the standard hex glyphs.
- Button path (one instance per button):
  - Invert the raw input, then pass it through a 2-flop synchroniser.
  - A counter increments while the synchronised level differs from the clean level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the clean level toggles and the counter clears.
  - press = one-cycle pulse on the clean 0→1 transition.
- Mode register (2 bits):
  - press0 alone: mode+1, wrapping 3→0.
  - press1 alone: mode−1, wrapping 0→3.
  - Both presses in the same cycle: mode unchanged.
- Result register (R bits) plus flag, loaded every cycle from the current switches:
  - Mode 0 ARITH:
    - op0: a+b; flag = sum > 2^W−1.
    - op1: a−b. If a<b, result = b−a and flag = 1 (negative); otherwise result = a−b and flag = 0.
    - op2: a*b; flag = 0.
    - op3: max(a,b); flag = 0.
  - Mode 1 LOGIC: op0 a&b, op1 a|b, op2 a^b, op3 ~(a&b). Operands are W bits, zero-extended to R bits; flag = 0.
  - Mode 2 COMPARE: op0 a==b, op1 a>b (unsigned), op2 a<b (unsigned), op3 min(a,b). Boolean results are 0 or 1; flag = 0.
  - Mode 3 CHASE: result = 0, flag = 0.
- Outputs, modes 0–2:
  - LEDs[R−1:0] = result.
  - LEDs[R] = 0.
  - LEDs[R+1] = flag.
  - result_seg = hex of result.
  - sign_seg = '-' only in mode 0 op1 with flag = 1; otherwise blank.
- Outputs, mode 3:
  - LEDs = one-hot at chase position pos.
  - result_seg and sign_seg blank.
- mode_seg always shows the mode number.
- Chase engine:
  - Tick counter runs 0..TICK_CYCLES−1 and ticks on wrap.
  - On each tick, pos moves one step in direction dir. It bounces at the ends: at pos = 2W+1 going up it reverses to down and moves to 2W; at pos 0 going down it reverses to up and moves to 1.
  - On any mode change, the tick counter, pos (to 0) and dir (to up) are cleared.

## Timing
- Reset (async assert, takes effect immediately):
  - Synchronisers, clean levels, counters: 0.
  - mode 0; result 0; flag 0; pos 0; dir up.
  - LEDs all 0.
  - result_seg all '0'.
  - sign_seg blank.
  - mode_seg '0'.
- Switch change → result/flag register on the next edge. LEDs and segments decode combinationally from registers: 1-cycle latency.
- Button latency: a raw press held continuously produces press at edge 2 + DEBOUNCE_CYCLES after the raw change; mode updates on the following edge.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is ignored (counter clears).
- Release is debounced identically and produces no event.
- Holding a button produces exactly one press event.
- The mode register updates in the same cycle as the chase clear.
- With TICK_CYCLES = 1, pos advances every cycle.

## Test plan
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, TICK_CYCLES=3.
- Reset with switches at any value → LEDs 0, result_seg "00", sign blank, mode_seg '0'. Assert reset_n low mid-operation → same values immediately, with no clock edge.
- Mode 0, op0, a=9, b=8 → one cycle later: result 0x11, LEDs = 10_00010001, digits "1","1". Then op2, a=15, b=15 → result 0xE1, digits "E","1", LEDs[9] = 0.
- Mode 0, op1, a=3, b=7 → result 4, sign_seg '-', LEDs[9] = 1. Then a=7, b=3 → result 4, sign blank, LEDs[9] = 0.
- Buttons:
  - Press buttons[1] held ≥10 cycles from mode 0 → exactly one step, to mode 3.
  - A 3-cycle buttons[0] glitch → no change.
  - Both buttons pressed in the same cycle → no change.
  - buttons[0] from mode 3 → mode 0.
- Mode 2, a=5, b=5: op0 → result 1; op1 → result 0; op3 → result 5.
- Mode 3:
  - LEDs one-hot, stepping every 3 cycles: 0,1,…,9,8,…,0,1.
  - Leaving and re-entering mode 3 restarts at pos 0 going up.
  - result_seg and sign_seg stay blank throughout.
